// File: rtl/sa_psum_accumulator.sv
// sa_psum_accumulator
//   Partial-sum accumulator placed directly after the 16-column systolic
//   array. Each column owns an independent lane with its own accumulation
//   buffer. Results from several input-channel passes are summed with
//   saturation. On the final pass each sum is arithmetically shifted,
//   optionally passed through ReLU, saturated to IN_W bits and streamed out.
//   There is no backpressure.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         one-cycle pulse that latches the configuration (IDLE only)
//   burst_size_i  results per column per pass, 1..DEPTH
//   num_pass_i    passes to accumulate (0 behaves as 1)
//   shift_i       arithmetic right shift applied to the final sum
//   relu_en_i     clamp negative final values to zero
//   accu_data_i   per-column signed partial result from the array
//   accu_valid_i  per-column valid, columns may be skewed arbitrarily
//   out_data_o    per-column saturated final result
//   out_valid_o   per-column output strobe, two cycles after the input valid
//   busy_o        high while the block is running
//   done_o        one-cycle pulse after the last lane's final output
module sa_psum_accumulator #(
  parameter int NUM_COL = 16,
  parameter int IN_W    = 8,
  parameter int ACC_W   = 16,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W:0]              burst_size_i,
  input  logic [3:0]                   num_pass_i,
  input  logic [3:0]                   shift_i,
  input  logic                         relu_en_i,
  input  logic [NUM_COL-1:0][IN_W-1:0] accu_data_i,
  input  logic [NUM_COL-1:0]           accu_valid_i,
  output logic [NUM_COL-1:0][IN_W-1:0] out_data_o,
  output logic [NUM_COL-1:0]           out_valid_o,
  output logic                         busy_o,
  output logic                         done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0]       DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]       ONE_B   = (ADDR_W+1)'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [IN_W-1:0]       OUT_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0]       OUT_MIN = {1'b1, {(IN_W-1){1'b0}}};

  state_t          state;
  logic [ADDR_W:0] burst_q;
  logic [3:0]      np_q;
  logic [3:0]      shift_q;
  logic            relu_q;
  logic            start_ok;
  logic [NUM_COL-1:0] lane_done_vec;
  logic [NUM_COL-1:0] pipe_busy_vec;

  // A start with an out-of-range burst is dropped and the block stays idle.
  assign start_ok = (state == IDLE) && start &&
                    (burst_size_i != '0) && (burst_size_i <= DEPTH_L);

  // Control FSM. DONE is entered only once every lane has finished and its
  // pipeline has drained, so done_o lands the cycle after the last strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      burst_q <= '0;
      np_q    <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_ok) begin
            burst_q <= burst_size_i;
            np_q    <= (num_pass_i == 4'd0) ? 4'd1 : num_pass_i;
            shift_q <= shift_i;
            relu_q  <= relu_en_i;
            busy_o  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if ((&lane_done_vec) && !(|pipe_busy_vec)) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_lane
    logic [ADDR_W-1:0]       addr;
    logic [ADDR_W-1:0]       s0_addr;
    logic [3:0]              pass;
    logic                    lane_done;
    logic                    accept;
    logic                    last_addr;
    logic                    s0_valid;
    logic                    s0_first;
    logic                    s0_final;
    logic [IN_W-1:0]         s0_data;
    logic                    fwd_sel;
    logic signed [ACC_W-1:0] fwd_data;
    logic signed [ACC_W-1:0] rd_ram;
    logic signed [ACC_W-1:0] prev;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W:0]   wide;
    logic [IN_W-1:0]         out_byte;
    logic                    out_valid_q;
    logic [IN_W-1:0]         out_data_q;
    logic signed [ACC_W-1:0] mem [DEPTH];

    assign accept    = (state == RUN) && accu_valid_i[c] && !lane_done;
    assign last_addr = ({1'b0, addr} == (burst_q - ONE_B));

    // The RAM read issued in the same cycle as the previous write to that
    // address returns old data, so the registered in-flight sum is used.
    assign prev = fwd_sel ? fwd_data : rd_ram;

    // Stage-1 arithmetic: pass 0 overwrites, later passes add with
    // saturation; the final value is shifted, ReLU'd and clamped to IN_W.
    always_comb begin
      wide = {prev[ACC_W-1], prev} + {{(ACC_W+1-IN_W){s0_data[IN_W-1]}}, s0_data};
      if (s0_first)
        sum = {{(ACC_W-IN_W){s0_data[IN_W-1]}}, s0_data};
      else if (wide[ACC_W] != wide[ACC_W-1])
        sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
      else
        sum = wide[ACC_W-1:0];
      shifted = sum >>> shift_q;
      v = (relu_q && shifted[ACC_W-1]) ? '0 : shifted;
      if (v[ACC_W-1:IN_W-1] == {(ACC_W-IN_W+1){v[ACC_W-1]}})
        out_byte = v[IN_W-1:0];
      else
        out_byte = v[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end

    // Lane counters, stage-0 capture and the registered output stage.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        addr        <= '0;
        pass        <= '0;
        lane_done   <= 1'b0;
        s0_valid    <= 1'b0;
        s0_first    <= 1'b0;
        s0_final    <= 1'b0;
        s0_addr     <= '0;
        s0_data     <= '0;
        fwd_sel     <= 1'b0;
        fwd_data    <= '0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        s0_valid    <= accept;
        fwd_sel     <= accept && s0_valid && (s0_addr == addr);
        fwd_data    <= sum;
        out_valid_q <= s0_valid && s0_final;
        if (s0_valid && s0_final)
          out_data_q <= out_byte;
        if (accept) begin
          s0_addr  <= addr;
          s0_data  <= accu_data_i[c];
          s0_first <= (pass == 4'd0);
          s0_final <= (pass == (np_q - 4'd1));
        end
        if (start_ok) begin
          addr      <= '0;
          pass      <= '0;
          lane_done <= 1'b0;
        end else if (accept) begin
          if (last_addr) begin
            addr <= '0;
            if (pass == (np_q - 4'd1))
              lane_done <= 1'b1;
            else
              pass <= pass + 4'd1;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
      end
    end

    // Accumulation buffer; writes are suppressed under reset so in-flight
    // results are dropped.
    always_ff @(posedge clk) begin
      if (accept)
        rd_ram <= mem[addr];
      if (rst_n && s0_valid)
        mem[s0_addr] <= sum;
    end

    assign lane_done_vec[c] = lane_done;
    assign pipe_busy_vec[c] = s0_valid;
    assign out_valid_o[c]   = out_valid_q;
    assign out_data_o[c]    = out_data_q;
  end

endmodule

// File: tb/tb_sa_psum_accumulator.sv
// tb_sa_psum_accumulator
//   Directed self-checking bench for sa_psum_accumulator. A second instance
//   with a narrow accumulator shares the stimulus so that accumulator
//   saturation can be reached with legal input values.
module tb_sa_psum_accumulator;

  localparam int NUM_COL = 16;
  localparam int IN_W    = 8;
  localparam int ADDR_W  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst_n;
  logic                         start;
  logic [ADDR_W:0]              burst_size_i;
  logic [3:0]                   num_pass_i;
  logic [3:0]                   shift_i;
  logic                         relu_en_i;
  logic [NUM_COL-1:0][IN_W-1:0] accu_data_i;
  logic [NUM_COL-1:0]           accu_valid_i;
  logic [NUM_COL-1:0][IN_W-1:0] out_data_o;
  logic [NUM_COL-1:0]           out_valid_o;
  logic                         busy_o;
  logic                         done_o;
  logic [NUM_COL-1:0][IN_W-1:0] sat_data_o;
  logic [NUM_COL-1:0]           sat_valid_o;
  logic                         sat_busy_o;
  logic                         sat_done_o;

  int vectors     = 0;
  int miscompares = 0;

  // Shared stimulus/expectation table for lanes driven identically.
  logic [7:0] in_d [40];
  logic       in_v [40];
  logic [7:0] ex_d [40];
  logic       ex_v [40];

  sa_psum_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .burst_size_i (burst_size_i),
    .num_pass_i   (num_pass_i),
    .shift_i      (shift_i),
    .relu_en_i    (relu_en_i),
    .accu_data_i  (accu_data_i),
    .accu_valid_i (accu_valid_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  sa_psum_accumulator #(.ACC_W(10)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .burst_size_i (burst_size_i),
    .num_pass_i   (num_pass_i),
    .shift_i      (shift_i),
    .relu_en_i    (relu_en_i),
    .accu_data_i  (accu_data_i),
    .accu_valid_i (accu_valid_i),
    .out_data_o   (sat_data_o),
    .out_valid_o  (sat_valid_o),
    .busy_o       (sat_busy_o),
    .done_o       (sat_done_o)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic clear_table();
    for (int i = 0; i < 40; i++) begin
      in_d[i] = 8'h00;
      in_v[i] = 1'b0;
      ex_d[i] = 8'h00;
      ex_v[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    start        = 1'b0;
    accu_valid_i = '0;
    accu_data_i  = '0;
  endtask

  task automatic begin_run(input logic [ADDR_W:0] b, input logic [3:0] np,
                           input logic [3:0] sh, input logic rl);
    @(posedge clk);
    #1;
    start        = 1'b1;
    burst_size_i = b;
    num_pass_i   = np;
    shift_i      = sh;
    relu_en_i    = rl;
  endtask

  task automatic test_reset();
    $display("[TB] reset state");
    rst_n        = 1'b0;
    start        = 1'b1;
    burst_size_i = 11'd1;
    num_pass_i   = 4'd1;
    shift_i      = 4'd0;
    relu_en_i    = 1'b0;
    accu_valid_i = '1;
    accu_data_i  = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid_o !== '0 || out_data_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_out: got valid=%h data=%h, want 0", out_valid_o, out_data_o);
    end
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got busy=%b done=%b, want 0 0", busy_o, done_o);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_identity();
    logic [7:0]         pat [4];
    logic [NUM_COL-1:0] want_v;
    $display("[TB] single pass identity with column skew");
    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'hFD; pat[3] = 8'h7F;
    begin_run(11'd4, 4'd1, 4'd0, 1'b0);
    for (int t = 0; t < 23; t++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 0; c < NUM_COL; c++) begin
        accu_valid_i[c] = (t >= c) && (t < c + 4);
        accu_data_i[c]  = 8'h00;
        if ((t >= c) && (t < c + 4))
          accu_data_i[c] = pat[t-c];
      end
      @(negedge clk);
      want_v = '0;
      for (int c = 0; c < NUM_COL; c++)
        want_v[c] = (t - 2 >= c) && (t - 2 < c + 4);
      vectors++;
      if (out_valid_o !== want_v) begin
        miscompares++;
        $display("[TB] FAIL ident_valid t=%0d: got %h want %h", t, out_valid_o, want_v);
      end
      for (int c = 0; c < NUM_COL; c++) begin
        if (want_v[c]) begin
          vectors++;
          if (out_data_o[c] !== pat[t-2-c]) begin
            miscompares++;
            $display("[TB] FAIL ident_data t=%0d col=%0d: got %h want %h", t, c, out_data_o[c], pat[t-2-c]);
          end
        end
      end
      vectors++;
      if (done_o !== (t == 21) || busy_o !== (t < 21)) begin
        miscompares++;
        $display("[TB] FAIL ident_ctrl t=%0d: got done=%b busy=%b want done=%b busy=%b", t, done_o, busy_o, t == 21, t < 21);
      end
    end
    idle_inputs();
  endtask

  task automatic test_multi_pass();
    $display("[TB] three-pass accumulate");
    clear_table();
    for (int t = 0; t < 6; t++) begin
      in_v[t] = 1'b1;
      in_d[t] = (t % 2 == 0) ? 8'd50 : 8'hF6;
    end
    ex_v[6] = 1'b1; ex_d[6] = 8'h7F;
    ex_v[7] = 1'b1; ex_d[7] = 8'hE2;
    begin_run(11'd2, 4'd3, 4'd0, 1'b0);
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      #1;
      start        = 1'b0;
      accu_valid_i = {NUM_COL{in_v[t]}};
      accu_data_i  = {NUM_COL{in_d[t]}};
      @(negedge clk);
      vectors++;
      if (out_valid_o !== {NUM_COL{ex_v[t]}}) begin
        miscompares++;
        $display("[TB] FAIL multi_valid t=%0d: got %h want %h", t, out_valid_o, {NUM_COL{ex_v[t]}});
      end
      if (ex_v[t]) begin
        vectors++;
        if (out_data_o !== {NUM_COL{ex_d[t]}}) begin
          miscompares++;
          $display("[TB] FAIL multi_data t=%0d: got %h want %h", t, out_data_o, {NUM_COL{ex_d[t]}});
        end
      end
      vectors++;
      if (done_o !== (t == 8) || busy_o !== (t < 8)) begin
        miscompares++;
        $display("[TB] FAIL multi_ctrl t=%0d: got done=%b busy=%b want done=%b busy=%b", t, done_o, busy_o, t == 8, t < 8);
      end
    end
    idle_inputs();
  endtask

  task automatic test_shift_relu();
    logic [7:0] din  [3];
    logic       rel  [3];
    logic [7:0] want [3];
    $display("[TB] shift, relu and burst-1 forwarding");
    din[0] = 8'd100; rel[0] = 1'b1; want[0] = 8'h32;
    din[1] = 8'h9C;  rel[1] = 1'b1; want[1] = 8'h00;
    din[2] = 8'h9C;  rel[2] = 1'b0; want[2] = 8'hCE;
    for (int r = 0; r < 3; r++) begin
      clear_table();
      in_v[0] = 1'b1; in_d[0] = din[r];
      in_v[1] = 1'b1; in_d[1] = din[r];
      ex_v[3] = 1'b1; ex_d[3] = want[r];
      begin_run(11'd1, 4'd2, 4'd2, rel[r]);
      for (int t = 0; t < 6; t++) begin
        @(posedge clk);
        #1;
        start        = 1'b0;
        accu_valid_i = {NUM_COL{in_v[t]}};
        accu_data_i  = {NUM_COL{in_d[t]}};
        @(negedge clk);
        vectors++;
        if (out_valid_o !== {NUM_COL{ex_v[t]}}) begin
          miscompares++;
          $display("[TB] FAIL shift_valid run=%0d t=%0d: got %h want %h", r, t, out_valid_o, {NUM_COL{ex_v[t]}});
        end
        if (ex_v[t]) begin
          vectors++;
          if (out_data_o !== {NUM_COL{ex_d[t]}}) begin
            miscompares++;
            $display("[TB] FAIL shift_data run=%0d t=%0d: got %h want %h", r, t, out_data_o, {NUM_COL{ex_d[t]}});
          end
        end
        vectors++;
        if (done_o !== (t == 4) || busy_o !== (t < 4)) begin
          miscompares++;
          $display("[TB] FAIL shift_ctrl run=%0d t=%0d: got done=%b busy=%b want done=%b busy=%b", r, t, done_o, busy_o, t == 4, t < 4);
        end
      end
      idle_inputs();
    end
  endtask

  task automatic test_saturation();
    logic [7:0] din   [2];
    logic [7:0] wmain [2];
    logic [7:0] wsat  [2];
    $display("[TB] fifteen-pass accumulate and accumulator saturation");
    // 15*127=1905>>>8=7; a 10-bit accumulator clamps at 511>>>8=1.
    // 15*-128=-1920>>>8=-8; the 10-bit one clamps at -512>>>8=-2.
    din[0] = 8'h7F; wmain[0] = 8'h07; wsat[0] = 8'h01;
    din[1] = 8'h80; wmain[1] = 8'hF8; wsat[1] = 8'hFE;
    for (int r = 0; r < 2; r++) begin
      clear_table();
      for (int t = 0; t < 15; t++) begin
        in_v[t] = 1'b1;
        in_d[t] = din[r];
      end
      begin_run(11'd1, 4'd15, 4'd8, 1'b0);
      for (int t = 0; t < 19; t++) begin
        @(posedge clk);
        #1;
        start        = 1'b0;
        accu_valid_i = {NUM_COL{in_v[t]}};
        accu_data_i  = {NUM_COL{in_d[t]}};
        @(negedge clk);
        vectors++;
        if (out_valid_o !== {NUM_COL{t == 16}} || sat_valid_o !== {NUM_COL{t == 16}}) begin
          miscompares++;
          $display("[TB] FAIL sat_valid run=%0d t=%0d: got %h/%h want %h", r, t, out_valid_o, sat_valid_o, {NUM_COL{t == 16}});
        end
        if (t == 16) begin
          vectors++;
          if (out_data_o !== {NUM_COL{wmain[r]}}) begin
            miscompares++;
            $display("[TB] FAIL sat_main_data run=%0d: got %h want %h", r, out_data_o, {NUM_COL{wmain[r]}});
          end
          vectors++;
          if (sat_data_o !== {NUM_COL{wsat[r]}}) begin
            miscompares++;
            $display("[TB] FAIL sat_clamp_data run=%0d: got %h want %h", r, sat_data_o, {NUM_COL{wsat[r]}});
          end
        end
        vectors++;
        if (done_o !== (t == 17) || busy_o !== (t < 17)) begin
          miscompares++;
          $display("[TB] FAIL sat_ctrl run=%0d t=%0d: got done=%b busy=%b want done=%b busy=%b", r, t, done_o, busy_o, t == 17, t < 17);
        end
      end
      idle_inputs();
    end
  endtask

  task automatic test_bad_start();
    logic [ADDR_W:0] bad [2];
    $display("[TB] out-of-range burst and valids while idle");
    bad[0] = 11'd0;
    bad[1] = 11'd1025;
    for (int r = 0; r < 2; r++) begin
      clear_table();
      for (int t = 0; t < 4; t++) begin
        in_v[t] = 1'b1;
        in_d[t] = 8'd33;
      end
      begin_run(bad[r], 4'd1, 4'd0, 1'b0);
      for (int t = 0; t < 4; t++) begin
        @(posedge clk);
        #1;
        start        = 1'b0;
        accu_valid_i = {NUM_COL{in_v[t]}};
        accu_data_i  = {NUM_COL{in_d[t]}};
        @(negedge clk);
        vectors++;
        if (out_valid_o !== '0) begin
          miscompares++;
          $display("[TB] FAIL bad_valid run=%0d t=%0d: got %h want 0", r, t, out_valid_o);
        end
        vectors++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL bad_ctrl run=%0d t=%0d: got done=%b busy=%b want 0 0", r, t, done_o, busy_o);
        end
      end
      idle_inputs();
    end
  endtask

  task automatic test_num_pass_zero();
    $display("[TB] num_pass 0 behaves as 1");
    clear_table();
    in_v[0] = 1'b1; in_d[0] = 8'd5;
    ex_v[2] = 1'b1; ex_d[2] = 8'd5;
    begin_run(11'd1, 4'd0, 4'd0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk);
      #1;
      start        = 1'b0;
      accu_valid_i = {NUM_COL{in_v[t]}};
      accu_data_i  = {NUM_COL{in_d[t]}};
      @(negedge clk);
      vectors++;
      if (out_valid_o !== {NUM_COL{ex_v[t]}}) begin
        miscompares++;
        $display("[TB] FAIL np0_valid t=%0d: got %h want %h", t, out_valid_o, {NUM_COL{ex_v[t]}});
      end
      if (ex_v[t]) begin
        vectors++;
        if (out_data_o !== {NUM_COL{ex_d[t]}}) begin
          miscompares++;
          $display("[TB] FAIL np0_data t=%0d: got %h want %h", t, out_data_o, {NUM_COL{ex_d[t]}});
        end
      end
      vectors++;
      if (done_o !== (t == 3) || busy_o !== (t < 3)) begin
        miscompares++;
        $display("[TB] FAIL np0_ctrl t=%0d: got done=%b busy=%b want done=%b busy=%b", t, done_o, busy_o, t == 3, t < 3);
      end
    end
    idle_inputs();
  endtask

  task automatic test_start_in_run();
    $display("[TB] start while running is ignored");
    clear_table();
    in_v[0] = 1'b1; in_d[0] = 8'd7;
    in_v[1] = 1'b1; in_d[1] = 8'd8;
    ex_v[2] = 1'b1; ex_d[2] = 8'd7;
    ex_v[3] = 1'b1; ex_d[3] = 8'd8;
    begin_run(11'd2, 4'd1, 4'd0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (t == 1) begin
        start        = 1'b1;
        burst_size_i = 11'd1;
        num_pass_i   = 4'd2;
      end
      accu_valid_i = {NUM_COL{in_v[t]}};
      accu_data_i  = {NUM_COL{in_d[t]}};
      @(negedge clk);
      vectors++;
      if (out_valid_o !== {NUM_COL{ex_v[t]}}) begin
        miscompares++;
        $display("[TB] FAIL sir_valid t=%0d: got %h want %h", t, out_valid_o, {NUM_COL{ex_v[t]}});
      end
      if (ex_v[t]) begin
        vectors++;
        if (out_data_o !== {NUM_COL{ex_d[t]}}) begin
          miscompares++;
          $display("[TB] FAIL sir_data t=%0d: got %h want %h", t, out_data_o, {NUM_COL{ex_d[t]}});
        end
      end
      vectors++;
      if (done_o !== (t == 4) || busy_o !== (t < 4)) begin
        miscompares++;
        $display("[TB] FAIL sir_ctrl t=%0d: got done=%b busy=%b want done=%b busy=%b", t, done_o, busy_o, t == 4, t < 4);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    $display("[TB] reset during a run, then a clean run");
    clear_table();
    in_v[0] = 1'b1; in_d[0] = 8'd9;
    in_v[1] = 1'b1; in_d[1] = 8'd9;
    in_v[2] = 1'b1; in_d[2] = 8'd11;
    begin_run(11'd2, 4'd2, 4'd0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk);
      #1;
      start        = 1'b0;
      accu_valid_i = {NUM_COL{in_v[t]}};
      accu_data_i  = {NUM_COL{in_d[t]}};
      rst_n        = (t != 3);
      @(negedge clk);
      vectors++;
      if (out_valid_o !== '0) begin
        miscompares++;
        $display("[TB] FAIL rmid_valid t=%0d: got %h want 0", t, out_valid_o);
      end
      vectors++;
      if (busy_o !== (t < 4) || done_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rmid_ctrl t=%0d: got busy=%b done=%b want busy=%b done=0", t, busy_o, done_o, t < 4);
      end
      if (t == 4) begin
        vectors++;
        if (out_data_o !== '0) begin
          miscompares++;
          $display("[TB] FAIL rmid_data: got %h want 0", out_data_o);
        end
      end
    end
    idle_inputs();
    clear_table();
    in_v[0] = 1'b1; in_d[0] = 8'd1;
    in_v[1] = 1'b1; in_d[1] = 8'd2;
    in_v[2] = 1'b1; in_d[2] = 8'd3;
    in_v[3] = 1'b1; in_d[3] = 8'd4;
    ex_v[4] = 1'b1; ex_d[4] = 8'd4;
    ex_v[5] = 1'b1; ex_d[5] = 8'd6;
    begin_run(11'd2, 4'd2, 4'd0, 1'b0);
    for (int t = 0; t < 8; t++) begin
      @(posedge clk);
      #1;
      start        = 1'b0;
      accu_valid_i = {NUM_COL{in_v[t]}};
      accu_data_i  = {NUM_COL{in_d[t]}};
      @(negedge clk);
      vectors++;
      if (out_valid_o !== {NUM_COL{ex_v[t]}}) begin
        miscompares++;
        $display("[TB] FAIL rpost_valid t=%0d: got %h want %h", t, out_valid_o, {NUM_COL{ex_v[t]}});
      end
      if (ex_v[t]) begin
        vectors++;
        if (out_data_o !== {NUM_COL{ex_d[t]}}) begin
          miscompares++;
          $display("[TB] FAIL rpost_data t=%0d: got %h want %h", t, out_data_o, {NUM_COL{ex_d[t]}});
        end
      end
      vectors++;
      if (done_o !== (t == 6) || busy_o !== (t < 6)) begin
        miscompares++;
        $display("[TB] FAIL rpost_ctrl t=%0d: got done=%b busy=%b want done=%b busy=%b", t, done_o, busy_o, t == 6, t < 6);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_multi_pass();
    test_shift_relu();
    test_saturation();
    test_bad_start();
    test_num_pass_zero();
    test_start_in_run();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sa_psum_accumulator.md
Name: sa_psum_accumulator

Overview:
- Sits directly downstream of the 16-column systolic array; consumes its per-column 8-bit partial results and valid strobes.
- Accumulates partial sums over several input-channel passes, each of `burst_size_i` results per column.
- On the final pass, applies arithmetic shift, optional ReLU and signed saturation to 8 bits, and streams the results to the writeback stage.
- There is no backpressure, matching the array's valid-only interface.

Parameters:
- NUM_COL, 16, number of array columns / independent accumulator lanes
- IN_W, 8, input partial-sum width (signed two's complement)
- ACC_W, 16, accumulator width (signed)
- DEPTH, 1024, accumulation buffer entries per column
- ADDR_W, 10, log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; latches config and arms the block (honoured in IDLE only)
- burst_size_i  in  11  results per column per pass, 1..DEPTH
- num_pass_i  in  4  number of passes to accumulate; 0 is treated as 1
- shift_i  in  4  arithmetic right shift applied to the final sum
- relu_en_i  in  1  1 = clamp negative final values to 0
- accu_data_i  in  NUM_COL x IN_W  per-column partial result from the array
- accu_valid_i  in  NUM_COL x 1  per-column valid; columns may be arbitrarily skewed
- out_data_o  out  NUM_COL x IN_W  per-column final 8-bit result
- out_valid_o  out  NUM_COL x 1  per-column output strobe
- busy_o  out  1  high while in RUN
- done_o  out  1  one-cycle pulse when every column has finished its final pass

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all per-column address and pass counters 0. Buffer RAM contents are not cleared, because pass 0 overwrites them.
- FSM states:
  - IDLE: on `start`, latch `burst_size_i`, `max(num_pass_i,1)`, `shift_i` and `relu_en_i`; clear counters; go to RUN. A `start` with `burst_size_i==0` or `>DEPTH` is ignored and the block stays in IDLE.
  - RUN: process valids. When all lanes have set `lane_done`, go to DONE.
  - DONE: assert `done_o` for exactly 1 cycle, then return to IDLE.
- Column `accu_valid_i` in IDLE or DONE is ignored. `start` in RUN or DONE is ignored.
- Per lane (independent, no cross-lane alignment assumed):
  - Counters: `addr` counts 0..burst-1. When `addr` wraps to 0, `pass` increments. After the last entry of pass `num_pass-1`, `lane_done` is set and further valids on that lane are ignored.
  - Pipeline cycle 0 (valid sampled): register data, addr and pass flags; issue a synchronous buffer read at addr.
  - Pipeline cycle 1: `sum` = (pass==0) ? sign-extend(data) : saturate_ACC_W(rd + sign-extend(data)). Write `sum` to addr. If this is the final pass, register the output stage.
  - Read-after-write hazard: if the cycle-0 read address equals the cycle-1 write address of the same lane (burst_size 1 with back-to-back valids), the in-flight `sum` is forwarded instead of the RAM data. This forwarding is mandatory.
  - Accumulator saturation: the result clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1], never wraps.
- Final-pass output:
  - `v` = sum >>> shift (arithmetic).
  - If `relu_en`, `v` = max(v,0).
  - `out_data_o` = clamp(v, -128, 127).
  - `out_valid_o[c]` rises exactly 2 cycles after the corresponding `accu_valid_i[c]`; one result per accepted input.
- Non-final passes produce no `out_valid_o`.
- `done_o` is asserted the cycle after the last lane's final output strobe.
- Mid-operation reset: state returns to IDLE and counters and outputs go to 0 on the next edge; any in-flight results are dropped.
- Valid on every cycle per lane is sustained (throughput 1/cycle/lane).

Test Plan:
- **Single pass, identity:** num_pass=1, burst=4, shift=0, relu=0; all columns send 1,2,-3,127 with skew c cycles -> each lane outputs 1,2,-3,127 at input+2 cycles; `done_o` pulses once after column 15 finishes.
- **Three-pass accumulate:** num_pass=3, burst=2; every pass sends 50,-10 -> outputs appear only in pass 3: 127 (150 saturated) and -30.
- **Shift and ReLU:** num_pass=2, burst=1, shift=2, relu=1; inputs 100,100 -> 50 (200>>>2). Inputs -100,-100 -> 0 (-50 clamped by ReLU). Both rely on burst-1 forwarding with back-to-back valids.
- **ACC_W saturation:** num_pass=15, burst=1, shift=8; every pass 127 gives 1905, output 7. Separately, force the buffer near +32767 via a long-pass bench model and confirm clamping to 32767 with no wrap.
- **Boundary control:** start with burst=0 -> stays IDLE, `busy_o`=0. Start during RUN -> ignored. Valids while IDLE -> no outputs. num_pass_i=0 -> behaves as 1.
- **Reset mid-RUN:** assert rst_n=0 in pass 1 -> next cycle all outputs 0 and IDLE. A new start with pass-0 data gives correct results, unaffected by stale buffer contents.
